// File: rtl/hba_pkg.sv
// Shared HBA bus definitions: widths, address field bounds, slave FSM states.
package hba_pkg;

  localparam int unsigned HBA_ABUS_W     = 12;
  localparam int unsigned HBA_DBUS_W     = 8;

  localparam int unsigned HBA_PERIPH_MSB = 11;
  localparam int unsigned HBA_PERIPH_LSB = 8;
  localparam int unsigned HBA_PERIPH_W   = HBA_PERIPH_MSB - HBA_PERIPH_LSB + 1;
  localparam int unsigned HBA_REG_MSB    = 7;
  localparam int unsigned HBA_REG_LSB    = 0;
  localparam int unsigned HBA_REG_W      = HBA_REG_MSB - HBA_REG_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } hba_state_e;

  // Bit offset of register i inside a flattened register vector
  function automatic int unsigned reg_slice(input int unsigned i);
    return i * HBA_DBUS_W;
  endfunction

endpackage

// File: rtl/hba_reg_bank.sv
// HBA bus slave exposing a bank of 8-bit registers; one ack per transfer,
// registered read data that is zero outside the ack cycle of a read.
module hba_reg_bank
  import hba_pkg::*;
#(
  parameter logic [HBA_PERIPH_W-1:0] PERIPH_ADDR = 4'd0,
  parameter int unsigned             NUM_REGS    = 4,
  parameter logic [15:0]             REG_WR_MASK = 16'h000F
) (
  input  logic                           hba_clk,
  input  logic                           hba_resetn,
  input  logic [HBA_ABUS_W-1:0]          hba_abus,
  input  logic                           hba_rnw,
  input  logic [HBA_DBUS_W-1:0]          hba_dbus,
  output logic                           slv_xferack,
  output logic [HBA_DBUS_W-1:0]          slv_dbus,
  output logic [HBA_DBUS_W*NUM_REGS-1:0] slv_reg_out,
  input  logic [HBA_DBUS_W*NUM_REGS-1:0] slv_reg_in,
  output logic [NUM_REGS-1:0]            slv_wr_strobe
);

  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned BANK_W = HBA_DBUS_W * NUM_REGS;

  hba_state_e              state_q, state_d;
  logic                    xferack_q, xferack_d;
  logic [HBA_DBUS_W-1:0]   dbus_q, dbus_d;
  logic [NUM_REGS-1:0]     strobe_q, strobe_d;
  logic [BANK_W-1:0]       bank_q, bank_d;

  logic                    sel_c;
  logic [HBA_REG_W-1:0]    idx_c;
  logic [HBA_DBUS_W-1:0]   rd_data_c;

  // Address decode: our peripheral field and a non-idle bus
  always_comb begin
    sel_c = (hba_abus[HBA_PERIPH_MSB:HBA_PERIPH_LSB] == PERIPH_ADDR) &&
            (hba_abus != '0);
    idx_c = hba_abus[HBA_REG_MSB:HBA_REG_LSB];
  end

  // Read mux: bank for writable slots, live input for read-only, 0 if out of range
  always_comb begin
    rd_data_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx_c == HBA_REG_W'(i)) begin
        if (REG_WR_MASK[4'(i)]) begin
          rd_data_c = bank_q[reg_slice(i) +: HBA_DBUS_W];
        end else begin
          rd_data_c = slv_reg_in[reg_slice(i) +: HBA_DBUS_W];
        end
      end
    end
  end

  // Transfer FSM: capture/perform the access on entry to ACK, then wait for release
  always_comb begin
    state_d   = state_q;
    xferack_d = 1'b0;
    dbus_d    = '0;
    strobe_d  = '0;
    bank_d    = bank_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_c) begin
          state_d   = ST_ACK;
          xferack_d = 1'b1;
          if (hba_rnw) begin
            dbus_d = rd_data_c;
          end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if ((idx_c == HBA_REG_W'(i)) && REG_WR_MASK[4'(i)]) begin
                bank_d[reg_slice(i) +: HBA_DBUS_W] = hba_dbus;
                strobe_d[IDX_W'(i)]                = 1'b1;
              end
            end
          end
        end
      end
      ST_ACK: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!sel_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge hba_clk or negedge hba_resetn) begin
    if (!hba_resetn) begin
      state_q   <= ST_IDLE;
      xferack_q <= 1'b0;
      dbus_q    <= '0;
      strobe_q  <= '0;
      bank_q    <= '0;
    end else begin
      state_q   <= state_d;
      xferack_q <= xferack_d;
      dbus_q    <= dbus_d;
      strobe_q  <= strobe_d;
      bank_q    <= bank_d;
    end
  end

  // Register outputs; read-only slots read back as zero
  always_comb begin
    slv_reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (REG_WR_MASK[4'(i)]) begin
        slv_reg_out[reg_slice(i) +: HBA_DBUS_W] = bank_q[reg_slice(i) +: HBA_DBUS_W];
      end
    end
  end

  always_comb begin
    slv_xferack   = xferack_q;
    slv_dbus      = dbus_q;
    slv_wr_strobe = strobe_q;
  end

endmodule

// File: tb/tb_hba_reg_bank.sv
// Self-checking bench: two slaves at peripheral 3 (all-writable and
// regs 0..1 writable) share one bus, checked against a register-array model.
module tb_hba_reg_bank;

  logic        hba_clk = 1'b0;
  logic        hba_resetn = 1'b0;
  logic [11:0] hba_abus = '0;
  logic        hba_rnw = 1'b0;
  logic [7:0]  hba_dbus = '0;
  logic [31:0] reg_in = '0;

  logic [1:0]  ack;
  logic [7:0]  rdat [2];
  logic [31:0] rout [2];
  logic [3:0]  strb [2];

  logic [3:0]  mask_v [2] = '{4'hF, 4'h3};
  logic [7:0]  m_bank [2][4];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always #5 hba_clk = ~hba_clk;
  always @(posedge hba_clk) cyc <= cyc + 1;

  hba_reg_bank #(.PERIPH_ADDR(4'd3), .NUM_REGS(4), .REG_WR_MASK(16'h000F)) dut0 (
    .hba_clk(hba_clk), .hba_resetn(hba_resetn), .hba_abus(hba_abus),
    .hba_rnw(hba_rnw), .hba_dbus(hba_dbus), .slv_xferack(ack[0]),
    .slv_dbus(rdat[0]), .slv_reg_out(rout[0]), .slv_reg_in(reg_in),
    .slv_wr_strobe(strb[0]));

  hba_reg_bank #(.PERIPH_ADDR(4'd3), .NUM_REGS(4), .REG_WR_MASK(16'h0003)) dut1 (
    .hba_clk(hba_clk), .hba_resetn(hba_resetn), .hba_abus(hba_abus),
    .hba_rnw(hba_rnw), .hba_dbus(hba_dbus), .slv_xferack(ack[1]),
    .slv_dbus(rdat[1]), .slv_reg_out(rout[1]), .slv_reg_in(reg_in),
    .slv_wr_strobe(strb[1]));

  function automatic logic [31:0] model_out(input int k);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (mask_v[k][i]) r[8*i +: 8] = m_bank[k][i];
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) for (int i = 0; i < 4; i++) m_bank[k][i] = 8'h00;
  endtask

  // One full transfer from a negedge: select, ack cycle, hold, release, back to idle
  task automatic xfer(input logic [11:0] addr, input logic rnw, input logic [7:0] wd,
                      input int hold, input string nm);
    logic       sel;
    int         idx;
    logic [7:0] exp_d [2];
    logic [3:0] exp_s [2];
    sel = (addr[11:8] == 4'h3) && (addr != 12'h000);
    idx = int'(addr[7:0]);
    for (int k = 0; k < 2; k++) begin
      exp_d[k] = 8'h00;
      exp_s[k] = 4'h0;
      if (sel) begin
        if (rnw) begin
          if (idx < 4) exp_d[k] = mask_v[k][idx] ? m_bank[k][idx] : reg_in[8*idx +: 8];
        end else if (idx < 4 && mask_v[k][idx]) begin
          m_bank[k][idx] = wd;
          exp_s[k][idx]  = 1'b1;
        end
      end
    end
    hba_abus = addr; hba_rnw = rnw; hba_dbus = wd;
    @(posedge hba_clk); @(negedge hba_clk);
    for (int k = 0; k < 2; k++) begin
      n_total += 4;
      if (ack[k] !== sel) $display("FAIL %s ack dut%0d: got %b want %b", nm, k, ack[k], sel);
      else n_pass++;
      if (rdat[k] !== exp_d[k]) $display("FAIL %s rdata dut%0d: got %h want %h", nm, k, rdat[k], exp_d[k]);
      else n_pass++;
      if (strb[k] !== exp_s[k]) $display("FAIL %s strobe dut%0d: got %b want %b", nm, k, strb[k], exp_s[k]);
      else n_pass++;
      if (rout[k] !== model_out(k)) $display("FAIL %s regout dut%0d: got %h want %h", nm, k, rout[k], model_out(k));
      else n_pass++;
    end
    for (int h = 0; h < hold + 2; h++) begin
      if (h < hold) begin
        hba_dbus = 8'($urandom);
        hba_rnw  = 1'($urandom);
        if (sel) hba_abus = {4'h3, 8'($urandom)};
      end else begin
        hba_abus = 12'h000;
      end
      @(posedge hba_clk); @(negedge hba_clk);
      for (int k = 0; k < 2; k++) begin
        n_total += 3;
        if (ack[k] !== 1'b0 || rdat[k] !== 8'h00) $display("FAIL %s post-ack dut%0d cyc%0d: ack %b data %h want 0/00", nm, k, h, ack[k], rdat[k]);
        else n_pass++;
        if (strb[k] !== 4'h0) $display("FAIL %s post-strobe dut%0d: got %b want 0000", nm, k, strb[k]);
        else n_pass++;
        if (rout[k] !== model_out(k)) $display("FAIL %s post-regout dut%0d: got %h want %h", nm, k, rout[k], model_out(k));
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    model_clear();
    hba_resetn = 1'b0;
    repeat (2) @(posedge hba_clk);
    @(negedge hba_clk);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (ack[k] !== 1'b0 || rdat[k] !== 8'h00 || strb[k] !== 4'h0 || rout[k] !== 32'h0)
        $display("FAIL reset dut%0d: ack %b data %h strobe %b regout %h want all zero", k, ack[k], rdat[k], strb[k], rout[k]);
      else n_pass++;
    end
    hba_resetn = 1'b1;
    @(negedge hba_clk);
  endtask

  task automatic test_write_read();
    xfer(12'h301, 1'b0, 8'hA5, 0, "wr301");
    n_total++;
    if (rout[0][15:8] !== 8'hA5) $display("FAIL wr301 reg1: got %h want a5", rout[0][15:8]);
    else n_pass++;
    xfer(12'h301, 1'b1, 8'h00, 2, "rd301");
  endtask

  task automatic test_no_match();
    xfer(12'h201, 1'b0, 8'h3C, 9, "nomatch_wr");
    xfer(12'h201, 1'b1, 8'h00, 9, "nomatch_rd");
  endtask

  task automatic test_ro_oor();
    reg_in = $urandom;
    reg_in[31:24] = 8'h5C;
    xfer(12'h303, 1'b1, 8'h00, 1, "ro_rd303");
    xfer(12'h303, 1'b0, 8'hFF, 1, "ro_wr303");
    xfer(12'h303, 1'b1, 8'h00, 0, "ro_rd303b");
    xfer(12'h3F0, 1'b1, 8'h00, 0, "oor_rd3f0");
    xfer(12'h3F0, 1'b0, 8'h99, 0, "oor_wr3f0");
  endtask

  task automatic test_held();
    int n_ack;
    int t1;
    int t2;
    bit got;
    n_ack = 0;
    hba_abus = 12'h300; hba_rnw = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge hba_clk); @(negedge hba_clk);
      if (ack[0]) n_ack++;
    end
    n_total++;
    if (n_ack !== 1) $display("FAIL held acks: got %0d want 1", n_ack);
    else n_pass++;
    hba_abus = 12'h000;
    @(posedge hba_clk); @(negedge hba_clk);
    // Fresh transfer, then a one-cycle drop and reselect
    hba_abus = 12'h300; hba_rnw = 1'b1;
    @(posedge hba_clk); @(negedge hba_clk);
    t1 = cyc;
    n_total++;
    if (ack[0] !== 1'b1 || rdat[0] !== m_bank[0][0]) $display("FAIL reack first: ack %b data %h want 1/%h", ack[0], rdat[0], m_bank[0][0]);
    else n_pass++;
    @(posedge hba_clk); @(negedge hba_clk);
    hba_abus = 12'h000;
    @(posedge hba_clk); @(negedge hba_clk);
    hba_abus = 12'h300;
    got = 1'b0;
    t2 = 0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(posedge hba_clk); @(negedge hba_clk);
      if (ack[0]) begin got = 1'b1; t2 = cyc; end
    end
    n_total++;
    if (!got || (t2 - t1) != 3) $display("FAIL reack gap: seen %0d gap %0d want 1 gap 3", got, t2 - t1);
    else n_pass++;
    hba_abus = 12'h000;
    repeat (2) begin @(posedge hba_clk); @(negedge hba_clk); end
  endtask

  task automatic test_reset_mid();
    hba_abus = 12'h300; hba_rnw = 1'b0; hba_dbus = 8'h77;
    #1 hba_resetn = 1'b0;
    model_clear();
    @(posedge hba_clk); @(negedge hba_clk);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (ack[k] !== 1'b0 || rout[k] !== 32'h0) $display("FAIL rstmid hold dut%0d: ack %b regout %h want 0/0", k, ack[k], rout[k]);
      else n_pass++;
    end
    hba_resetn = 1'b1;
    for (int k = 0; k < 2; k++) m_bank[k][0] = 8'h77;
    @(posedge hba_clk); @(negedge hba_clk);
    for (int k = 0; k < 2; k++) begin
      n_total += 2;
      if (ack[k] !== 1'b1) $display("FAIL rstmid ack dut%0d: got %b want 1", k, ack[k]);
      else n_pass++;
      if (rout[k] !== model_out(k) || strb[k] !== 4'b0001) $display("FAIL rstmid write dut%0d: regout %h strobe %b want %h/0001", k, rout[k], strb[k], model_out(k));
      else n_pass++;
    end
    hba_abus = 12'h000;
    repeat (2) begin @(posedge hba_clk); @(negedge hba_clk); end
    n_total++;
    if (ack !== 2'b00) $display("FAIL rstmid single ack: got %b want 00", ack);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    xfer(12'h300, 1'b0, 8'h11, 0, "b2b0");
    xfer(12'h301, 1'b0, 8'h22, 0, "b2b1");
    xfer(12'h302, 1'b0, 8'h33, 0, "b2b2");
    xfer(12'h303, 1'b0, 8'h44, 0, "b2b3");
    n_total++;
    if (rout[0] !== 32'h44332211) $display("FAIL b2b regout: got %h want 44332211", rout[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [11:0] a;
    for (int t = 0; t < 40; t++) begin
      reg_in = $urandom;
      case ($urandom_range(0, 4))
        0:       a = {4'h3, 8'($urandom_range(4, 255))};
        1:       a = {4'($urandom_range(0, 15)), 8'($urandom)};
        2:       a = 12'h000;
        default: a = {4'h3, 8'($urandom_range(0, 3))};
      endcase
      xfer(a, 1'($urandom), 8'($urandom), int'($urandom_range(0, 3)), "rand");
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_read();
    test_no_match();
    test_ro_oor();
    test_held();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
